bb_sgpio_tx: RTL and testbench

//  Parametrised SGPIO initiator: serialises per-drive ACT/LOC/FAIL LED bits to the backplane and

---
 rtl/bb_sgpio_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_bb_sgpio_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bb_sgpio_tx.sv
// -----------------------------------------------------------------------------
// bb_sgpio_tx
// SGPIO initiator for the baseboard/backplane link. Each frame sends a one
// bit-time load marker and then ACT/LOC/FAIL for every drive. While the frame
// is sent, the returned SGPIO_DIN stream is captured. Only complete input
// frames are published, and FRAME_DONE pulses for one cycle when they are.
//
// Ports
//   SYSCLK         system clock
//   RESET          synchronous active-high reset (aborts any frame)
//   ENABLE         1: run frames back to back, 0: abort and idle
//   DRV_ACT        per-drive activity (inverted before transmit when ACT_INV=1)
//   DRV_LOC        per-drive locate request
//   DRV_FAIL       per-drive fail request
//   FAIL_BLINK     per-drive: FAIL bit gated by the blink phase
//   SGPIO_DIN      serial input from the backplane, sampled on SCK rise
//   SGPIO_CK       SGPIO clock, period 2*CLK_DIV SYSCLK cycles
//   SGPIO_LD       load / frame-start marker
//   SGPIO_DATA     serial output, updated on SCK fall
//   SGPIO_IN_DATA  last complete input frame, bit 3*i+k = drive i, slot k
//   FRAME_DONE     one-cycle pulse when SGPIO_IN_DATA updates
// -----------------------------------------------------------------------------
module bb_sgpio_tx #(
    parameter int HDD_NUM      = 36,
    parameter int CLK_DIV      = 250,
    parameter int BLINK_FRAMES = 8,
    parameter int ACT_INV      = 1
) (
    input  logic                   SYSCLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic [HDD_NUM-1:0]     DRV_ACT,
    input  logic [HDD_NUM-1:0]     DRV_LOC,
    input  logic [HDD_NUM-1:0]     DRV_FAIL,
    input  logic [HDD_NUM-1:0]     FAIL_BLINK,
    input  logic                   SGPIO_DIN,
    output logic                   SGPIO_CK,
    output logic                   SGPIO_LD,
    output logic                   SGPIO_DATA,
    output logic [3*HDD_NUM-1:0]   SGPIO_IN_DATA,
    output logic                   FRAME_DONE
);
    localparam int NBITS = 3 * HDD_NUM;
    localparam int BW    = $clog2(NBITS);
    localparam int CW    = $clog2(CLK_DIV);
    localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRM_MAX  = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sck_q, sck_d;
    logic                ld_q, ld_d;
    logic                data_q, data_d;
    logic [BW-1:0]       bitcnt_q, bitcnt_d;
    logic [HDD_NUM-1:0]  act_q, act_d, loc_q, loc_d, fail_q, fail_d, blink_q, blink_d;
    logic [NBITS-1:0]    cap_q, cap_d;
    logic [NBITS-1:0]    in_data_q, in_data_d;
    logic                done_q, done_d;
    logic [FW-1:0]       frm_q, frm_d;
    logic                phase_q, phase_d;

    logic                rise_s, fall_s, last_s, take_snap_s;
    logic [BW-1:0]       next_bit_s;
    logic [NBITS-1:0]    tx_vec_s;
    logic [NBITS-1:0]    cap_next_s;
    logic [HDD_NUM-1:0]  act_pol_s;

    assign act_pol_s  = (ACT_INV != 0) ? ~DRV_ACT : DRV_ACT;
    assign rise_s     = (cnt_q == CNT_MAX) && !sck_q;
    assign fall_s     = (cnt_q == CNT_MAX) && sck_q;
    assign last_s     = (bitcnt_q == LAST_BIT);
    assign next_bit_s = bitcnt_q + BW'(1);

    // Transmit vector built from the frame snapshot; blink phase is stable within a frame.
    for (genvar i = 0; i < HDD_NUM; i++) begin : g_tx
        assign tx_vec_s[3*i]   = act_q[i];
        assign tx_vec_s[3*i+1] = loc_q[i];
        assign tx_vec_s[3*i+2] = fail_q[i] & (~blink_q[i] | phase_q);
    end

    // Next-state logic: divider, frame sequencer, input capture and blink counter.
    always_comb begin
        state_d     = state_q;
        ld_d        = ld_q;
        data_d      = data_q;
        bitcnt_d    = bitcnt_q;
        act_d       = act_q;
        loc_d       = loc_q;
        fail_d      = fail_q;
        blink_d     = blink_q;
        cap_d       = cap_q;
        in_data_d   = in_data_q;
        done_d      = 1'b0;
        frm_d       = frm_q;
        phase_d     = phase_q;
        take_snap_s = 1'b0;
        cap_next_s  = cap_q;
        cap_next_s[bitcnt_q] = SGPIO_DIN;

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
            sck_d = sck_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    take_snap_s = 1'b1;
                    ld_d        = 1'b1;
                    data_d      = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (fall_s) begin
                    ld_d     = 1'b0;
                    data_d   = tx_vec_s[0];
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (rise_s) begin
                    cap_d = cap_next_s;
                    // The last bit completes the input frame: publish including this bit.
                    if (last_s) begin
                        in_data_d = cap_next_s;
                        done_d    = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end else if (fall_s) begin
                    if (!last_s) begin
                        bitcnt_d = next_bit_s;
                        data_d   = tx_vec_s[next_bit_s];
                    end else begin
                        take_snap_s = 1'b1;
                        ld_d        = 1'b1;
                        data_d      = 1'b0;
                        state_d     = ST_LOAD;
                        if (frm_q == FRM_MAX) begin
                            frm_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            frm_d = frm_q + FW'(1);
                        end
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Inputs are latched only at frame boundaries so mid-frame changes wait a frame.
        if (take_snap_s) begin
            act_d   = act_pol_s;
            loc_d   = DRV_LOC;
            fail_d  = DRV_FAIL;
            blink_d = FAIL_BLINK;
        end else begin
            act_d   = act_q;
        end
    end

    // State registers; ENABLE low aborts like reset but keeps published data and blink state.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sck_q     <= 1'b0;
            ld_q      <= 1'b0;
            data_q    <= 1'b0;
            bitcnt_q  <= '0;
            act_q     <= '0;
            loc_q     <= '0;
            fail_q    <= '0;
            blink_q   <= '0;
            cap_q     <= '0;
            in_data_q <= '0;
            done_q    <= 1'b0;
            frm_q     <= '0;
            phase_q   <= 1'b1;
        end else if (!ENABLE) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sck_q     <= 1'b0;
            ld_q      <= 1'b0;
            data_q    <= 1'b0;
            bitcnt_q  <= '0;
            cap_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sck_q     <= sck_d;
            ld_q      <= ld_d;
            data_q    <= data_d;
            bitcnt_q  <= bitcnt_d;
            act_q     <= act_d;
            loc_q     <= loc_d;
            fail_q    <= fail_d;
            blink_q   <= blink_d;
            cap_q     <= cap_d;
            in_data_q <= in_data_d;
            done_q    <= done_d;
            frm_q     <= frm_d;
            phase_q   <= phase_d;
        end
    end

    assign SGPIO_CK      = sck_q;
    assign SGPIO_LD      = ld_q;
    assign SGPIO_DATA    = data_q;
    assign SGPIO_IN_DATA = in_data_q;
    assign FRAME_DONE    = done_q;

endmodule

// File: tb/tb_bb_sgpio_tx.sv
// -----------------------------------------------------------------------------
// tb_bb_sgpio_tx
// Scoreboard bench for bb_sgpio_tx with HDD_NUM=2, CLK_DIV=2, BLINK_FRAMES=2
// and ACT_INV=1. The stimulus pushes hand-computed frames into queues.
// A monitor rebuilds each transmitted frame from SCK falls and checks every
// FRAME_DONE. The monitor also acts as the backplane and drives SGPIO_DIN.
// -----------------------------------------------------------------------------
module tb_bb_sgpio_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] act = 2'b00;
    logic [1:0] loc = 2'b00;
    logic [1:0] fail = 2'b00;
    logic [1:0] blk = 2'b00;
    logic       din = 1'b0;
    logic       ck_o, ld_o, data_o, done_o;
    logic [5:0] in_data_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int mon_pos = 0;
    bit mon_coll = 1'b0;
    logic [5:0] din_pat = 6'b000000;
    logic [5:0] exp_tx_q[$];
    logic [5:0] exp_in_q[$];

    bb_sgpio_tx #(
        .HDD_NUM(2), .CLK_DIV(2), .BLINK_FRAMES(2), .ACT_INV(1)
    ) dut (
        .SYSCLK(clk), .RESET(rst), .ENABLE(en),
        .DRV_ACT(act), .DRV_LOC(loc), .DRV_FAIL(fail), .FAIL_BLINK(blk),
        .SGPIO_DIN(din), .SGPIO_CK(ck_o), .SGPIO_LD(ld_o), .SGPIO_DATA(data_o),
        .SGPIO_IN_DATA(in_data_o), .FRAME_DONE(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name, input int actual, input int expected);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    endtask

    // Monitor + backplane responder: samples 2 time units after each rising edge.
    initial begin : monitor
        logic       prev_ck;
        logic       ld_bad;
        logic [5:0] obs;
        logic [5:0] e;
        int         last_done;
        prev_ck = 1'b0; ld_bad = 1'b0; obs = 6'b000000; last_done = -1;
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (rst || !en) begin
                mon_coll = 1'b0; mon_pos = 0; last_done = -1;
            end else begin
                if (done_o) begin
                    if (exp_in_q.size() == 0) fail_now("unexpected_frame_done", 1, 0);
                    else begin
                        e = exp_in_q.pop_front();
                        check("in_data", 32'(in_data_o), 32'(e));
                    end
                    if (last_done >= 0) check("done_interval", 32'(cyc - last_done), 32'd28);
                    last_done = cyc;
                    done_cnt++;
                end
                if (prev_ck && !ck_o) begin
                    if (!mon_coll) begin
                        if (ld_o) begin
                            mon_coll = 1'b1; mon_pos = 0; ld_bad = data_o;
                        end
                    end else begin
                        obs[mon_pos] = data_o;
                        if (ld_o) ld_bad = 1'b1;
                        din = din_pat[mon_pos];
                        mon_pos++;
                        if (mon_pos == 6) begin
                            if (exp_tx_q.size() == 0) fail_now("unexpected_tx_frame", 1, 0);
                            else begin
                                e = exp_tx_q.pop_front();
                                check("tx_frame", 32'({ld_bad, obs}), 32'({1'b0, e}));
                            end
                            mon_coll = 1'b0;
                        end
                    end
                end
            end
            prev_ck = ck_o;
        end
    end

    task automatic push_frame(input logic [5:0] tx, input logic [5:0] rx);
        exp_tx_q.push_back(tx);
        exp_in_q.push_back(rx);
    endtask

    task automatic finish_frames(input int base, input int n);
        int budget;
        budget = 40 * n + 40;
        while ((done_cnt < base + n) && (budget > 0)) begin
            @(negedge clk); budget--;
        end
        if (done_cnt < base + n) fail_now("frame_done_timeout", done_cnt - base, n);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
        check("in_queue_drained", 32'(exp_in_q.size()), 32'd0);
        exp_tx_q.delete();
        exp_in_q.delete();
    endtask

    task automatic run_frames(input int n);
        int base;
        base = done_cnt;
        @(negedge clk); en = 1'b1;
        finish_frames(base, n);
    endtask

    task automatic wait_bitpos(input int pos);
        int budget;
        budget = 80;
        while (!(mon_coll && mon_pos == pos) && budget > 0) begin
            @(negedge clk); budget--;
        end
        if (!(mon_coll && mon_pos == pos)) fail_now("bitpos_timeout", mon_pos, pos);
    endtask

    task automatic wait_rise(output int at);
        logic p;
        int   budget;
        p = ck_o; budget = 20; at = -1;
        while (budget > 0) begin
            @(negedge clk); budget--;
            if (!p && ck_o) begin
                at = cyc; budget = 0;
            end
            p = ck_o;
        end
        if (at < 0) fail_now("ck_rise_timeout", 0, 1);
    endtask

    initial begin : stim
        logic [5:0] blink_tab [6];
        int base, t_a, t_b;

        // Power-on reset
        repeat (3) @(negedge clk);
        check("rst_ck", 32'(ck_o), 32'd0);
        check("rst_ld", 32'(ld_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_in_data", 32'(in_data_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst = 1'b0;

        // Basic frame and input capture
        act = 2'b10; loc = 2'b01; fail = 2'b10; blk = 2'b00; din_pat = 6'b101101;
        for (int j = 0; j < 3; j++) push_frame(6'b100011, 6'b101101);
        run_frames(3);

        // Reset held three cycles mid-frame, then divider period
        en = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ck", 32'(ck_o), 32'd0);
        check("midrst_ld", 32'(ld_o), 32'd0);
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_in_data", 32'(in_data_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_rise(t_a);
        wait_rise(t_b);
        check("ck_period", 32'(t_b - t_a), 32'd4);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Blink: drive0 FAIL gated, drive1 FAIL steady
        act = 2'b11; loc = 2'b00; fail = 2'b11; blk = 2'b01; din_pat = 6'b010011;
        blink_tab = '{6'b100100, 6'b100100, 6'b100000, 6'b100000, 6'b100100, 6'b100100};
        for (int j = 0; j < 6; j++) push_frame(blink_tab[j], 6'b010011);
        run_frames(6);

        // Abort at bit 3, then re-enable
        act = 2'b00; loc = 2'b10; fail = 2'b00; blk = 2'b00; din_pat = 6'b110110;
        @(negedge clk); en = 1'b1;
        wait_bitpos(4);
        en = 1'b0;
        @(negedge clk);
        check("abort_ck", 32'(ck_o), 32'd0);
        check("abort_ld", 32'(ld_o), 32'd0);
        check("abort_data", 32'(data_o), 32'd0);
        check("abort_in_data", 32'(in_data_o), 32'(6'b010011));
        check("abort_done", 32'(done_o), 32'd0);
        repeat (40) @(negedge clk);
        check("abort_in_hold", 32'(in_data_o), 32'(6'b010011));
        push_frame(6'b011001, 6'b110110);
        run_frames(1);
        check("reenable_in_data", 32'(in_data_o), 32'(6'b110110));

        // Inputs change mid-frame: only the next frame follows
        act = 2'b01; loc = 2'b00; fail = 2'b01; blk = 2'b00; din_pat = 6'b011100;
        push_frame(6'b001100, 6'b011100);
        push_frame(6'b110011, 6'b011100);
        base = done_cnt;
        @(negedge clk); en = 1'b1;
        wait_bitpos(2);
        act = 2'b10; loc = 2'b11; fail = 2'b10;
        finish_frames(base, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
